// File: rtl/mem_if_pkg.sv
// Shared definitions for the SRAM-like memory bridges: size codes, bridge
// state encoding and the byte-enable to size/offset mapping.
package mem_if_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  typedef struct packed {
    logic [1:0] size;
    logic [1:0] off;
  } wen_enc_t;

  // Unrecognised enable patterns fall back to an aligned word access.
  function automatic wen_enc_t wen_to_enc(input logic [3:0] wen);
    wen_enc_t e;
    e.size = SIZE_WORD;
    e.off  = 2'b00;
    case (wen)
      4'b1111: begin e.size = SIZE_WORD; e.off = 2'b00; end
      4'b0011: begin e.size = SIZE_HALF; e.off = 2'b00; end
      4'b1100: begin e.size = SIZE_HALF; e.off = 2'b10; end
      4'b0001: begin e.size = SIZE_BYTE; e.off = 2'b00; end
      4'b0010: begin e.size = SIZE_BYTE; e.off = 2'b01; end
      4'b0100: begin e.size = SIZE_BYTE; e.off = 2'b10; end
      4'b1000: begin e.size = SIZE_BYTE; e.off = 2'b11; end
      default: begin e.size = SIZE_WORD; e.off = 2'b00; end
    endcase
    return e;
  endfunction

endpackage

// File: rtl/sram_like_drop_ctr.sv
// Counts responses still owed by the interconnect for abandoned requests.
// Saturates at both ends; a simultaneous inc and dec leaves the count alone.
module sram_like_drop_ctr #(
  parameter int MAX_DROP = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          inc,
  input  logic                          dec,
  output logic [$clog2(MAX_DROP+1)-1:0] count,
  output logic                          zero,
  output logic                          full
);

  localparam int CW = $clog2(MAX_DROP + 1);

  assign zero = (count == '0);
  assign full = (count == CW'(MAX_DROP));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && dec) begin
      count <= count;
    end else if (inc && !full) begin
      count <= count + CW'(1);
    end else if (dec && !zero) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/sram_like_bridge.sv
// Stalling SRAM-style CPU port to SRAM-like req/addr_ok/data_ok bridge with
// flush support: responses to abandoned requests are counted off and dropped.
module sram_like_bridge
  import mem_if_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter bit WRITE_EN = 1'b1,
  parameter int MAX_DROP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_en,
  input  logic [3:0]        cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic              cpu_flush,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  input  logic              longest_stall,
  output logic              req,
  output logic              wr,
  output logic [1:0]        size,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       wdata,
  input  logic              addr_ok,
  input  logic              data_ok,
  input  logic [31:0]       rdata
);

  localparam int CW = $clog2(MAX_DROP + 1);

  state_t          state, state_nxt;
  logic            flush_pend, flush_pend_nxt;
  logic [31:0]     hold;
  logic            launch, capture;
  logic            drop_inc, drop_dec;
  logic [CW-1:0]   drop_cnt;
  logic            drop_zero, drop_full;

  logic            is_wr;
  wen_enc_t        enc;
  logic [1:0]      launch_size;
  logic [ADDR_W-1:0] launch_addr;

  sram_like_drop_ctr #(.MAX_DROP(MAX_DROP)) u_drop (
    .clk   (clk),
    .rst   (rst),
    .inc   (drop_inc),
    .dec   (drop_dec),
    .count (drop_cnt),
    .zero  (drop_zero),
    .full  (drop_full)
  );

  assign is_wr       = WRITE_EN && (cpu_wen != 4'b0000);
  assign enc         = wen_to_enc(cpu_wen);
  assign launch_size = is_wr ? enc.size : SIZE_WORD;
  assign launch_addr = is_wr ? {cpu_addr[ADDR_W-1:2], enc.off} : cpu_addr;

  // Reset gates the stall so every output reads 0 while rst is held.
  assign cpu_stall = !rst && cpu_en && (state != DONE);
  assign req       = (state == REQ);
  assign cpu_rdata = hold;

  always_comb begin
    state_nxt      = state;
    flush_pend_nxt = flush_pend;
    launch         = 1'b0;
    capture        = 1'b0;
    drop_inc       = 1'b0;
    drop_dec       = data_ok && !drop_zero;
    case (state)
      IDLE: begin
        if (cpu_en && !cpu_flush && !drop_full) begin
          state_nxt      = REQ;
          launch         = 1'b1;
          flush_pend_nxt = 1'b0;
        end
      end
      REQ: begin
        // The request cannot be withdrawn; a flush only marks it abandoned.
        if (addr_ok) begin
          flush_pend_nxt = 1'b0;
          if (flush_pend || cpu_flush) begin
            drop_inc  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = WAIT;
          end
        end else if (cpu_flush) begin
          flush_pend_nxt = 1'b1;
        end
      end
      WAIT: begin
        if (cpu_flush) begin
          state_nxt = IDLE;
          drop_inc  = !(data_ok && drop_zero);
        end else if (data_ok && drop_zero) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (cpu_flush || !longest_stall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      flush_pend <= 1'b0;
      hold       <= '0;
      wr         <= 1'b0;
      size       <= '0;
      addr       <= '0;
      wdata      <= '0;
    end else begin
      state      <= state_nxt;
      flush_pend <= flush_pend_nxt;
      if (capture) hold <= rdata;
      if (launch) begin
        wr    <= is_wr;
        size  <= launch_size;
        addr  <= launch_addr;
        wdata <= WRITE_EN ? cpu_wdata : 32'h0;
      end
    end
  end

  a_no_stray_data_ok : assert property (@(posedge clk) disable iff (rst)
    !(data_ok && drop_zero && (state == IDLE || state == REQ)))
    else $error("sram_like_bridge: data_ok with no request outstanding");

endmodule

// File: doc/sram_like_bridge.md
Name: sram_like_bridge

Overview:
- Parametrised successor to the per-port inst/data SRAM to SRAM-like converters in the mips core.
- One instance serves either the instruction port (WRITE_EN=0) or the data port (WRITE_EN=1).
- Converts a stalling SRAM-style CPU access into SRAM-like req/addr_ok/data_ok transactions.
- Holds returned data until the core-wide longest_stall releases.
- New versus the previous generation: supports pipeline flush. Requests already accepted by the interconnect are tracked, and their late responses are discarded, up to MAX_DROP outstanding.

Parameters:
ADDR_W, 32, width of cpu_addr and addr.
WRITE_EN, 1, 1 = read/write data port; 0 = read-only instruction port (wr tied 0, wen ignored).
MAX_DROP, 2, maximum number of abandoned in-flight responses tracked (1..7).

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cpu_en  in  1  access request from datapath, held stable while cpu_stall=1
cpu_wen  in  4  byte write enables; 0 = read
cpu_addr  in  ADDR_W  byte address
cpu_wdata  in  32  write data, already byte-lane aligned
cpu_flush  in  1  single-cycle flush pulse (exception/eret)
cpu_rdata  out  32  read data, valid while state=DONE
cpu_stall  out  1  stall request to datapath
longest_stall  in  1  global stall (OR of all port stalls)
req  out  1  SRAM-like request
wr  out  1  1 = write
size  out  2  0 = byte, 1 = half, 2 = word
addr  out  ADDR_W  request address
wdata  out  32  write data
addr_ok  in  1  request accepted
data_ok  in  1  response or write completion (in order)
rdata  in  32  response data

Behaviour:
- Reset: all outputs 0, state IDLE, drop_cnt 0. Reset mid-transaction abandons everything; the interconnect is reset by the same rst.
- States:
  - IDLE: if cpu_en & ~cpu_flush & drop_cnt<MAX_DROP, go to REQ next cycle. cpu_stall is combinationally 1 in the same cycle.
  - REQ: req=1, with wr/size/addr/wdata registered on entry. On addr_ok, go to WAIT.
  - WAIT: on data_ok with drop_cnt==0, capture rdata into a hold register and go to DONE.
  - DONE: cpu_stall=0 and cpu_rdata=hold. Go to IDLE in the first cycle longest_stall=0.
- cpu_stall = cpu_en & (state!=DONE); it is also forced 1 in IDLE while drop_cnt==MAX_DROP and cpu_en=1.
- Latency: with addr_ok and data_ok each returned one cycle after req, cpu_stall is high for 3 cycles (IDLE, REQ, WAIT) and low in DONE.
- Request encoding for reads, and whenever WRITE_EN=0: wr=0, size=2, addr=cpu_addr.
- Request encoding for writes (cpu_wen!=0):
  - wr=1, wdata=cpu_wdata.
  - wen 1111: size=2, addr[1:0]=00.
  - wen 0011 or 1100: size=1, addr[1:0]=00 or 10.
  - wen 0001/0010/0100/1000: size=0, addr[1:0]=00/01/10/11.
  - Any other pattern: size=2, addr[1:0]=00.
  - Upper address bits come from cpu_addr.
- req stays high until addr_ok; it is never withdrawn, including on flush.
- Flush behaviour by state:
  - IDLE: no effect.
  - REQ: request remains issued. On addr_ok (same or later cycle), drop_cnt+1 and go to IDLE.
  - WAIT: drop_cnt+1 and go to IDLE, unless data_ok occurs the same cycle with drop_cnt==0. In that case the data is discarded, drop_cnt is unchanged, and the state goes to IDLE.
  - DONE: hold is discarded and the state goes to IDLE.
- Any data_ok with drop_cnt>0 is discarded and drop_cnt-1. Because responses return in order, a dropped response always precedes new data.
- Simultaneous drop_cnt+1 and -1 in one cycle leaves drop_cnt unchanged.
- A new request may issue while drop_cnt>0. Accepted writes are never cancelled; their data_ok is simply counted off.
- Unexpected data_ok in IDLE/REQ with drop_cnt==0 is a protocol error. It is ignored, and a simulation-only assertion fires.

Decomposition:
- Shared package mem_if_pkg: size encodings (SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2), state enum (IDLE/REQ/WAIT/DONE), and a wen-to-size/offset function.
- One natural sub-module, sram_like_drop_ctr: saturating up/down counter with full flag, width clog2(MAX_DROP+1).

Test Plan:
- Word read at 0xBFC00000, addr_ok/data_ok each 1 cycle after req, rdata=0x3C1D0001 -> req for 1 cycle, size=2, wr=0, cpu_stall high 3 cycles, cpu_rdata=0x3C1D0001 in DONE.
- Byte write, wen=0100, addr=0x80001233, wdata=0x00AB0000 -> wr=1, size=0, addr=0x80001232, wdata=0x00AB0000. Half write wen=1100 -> size=1, addr[1:0]=10.
- Read completes while longest_stall=1 for 4 extra cycles -> DONE held, cpu_stall=0, cpu_rdata stable, then IDLE.
- Flush in WAIT, then new read at 0x100. Old data_ok returns 0xDEAD, new returns 0x1234 -> 0xDEAD discarded, drop_cnt 1 then 0, cpu_rdata=0x1234.
- MAX_DROP=2: two flushes in WAIT with no data_ok -> third cpu_en is held stalled with req=0 until one data_ok arrives, then issues.
- Assert rst in REQ with req=1 -> req=0 and cpu_stall=0 immediately (asynchronous), drop_cnt=0, state IDLE.
